// File: rtl/fpu_flags.sv
// Shared FPU exception-flag types and the queue entry layout.
package fpu_flags;

  localparam int FLAG_WIDTH = 5;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } flag_set;

  // One queue entry: the single-precision result and its exception flags.
  typedef struct packed {
    logic [31:0] result;
    flag_set     flags;
  } entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Circular storage for FPU results: array, read/write pointers and occupancy.
// The caller only pushes when there is room (or a pop frees a slot in the
// same cycle) and only pops when not empty.
module fpu_result_fifo
  import fpu_flags::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wdata,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control state; reset discards every entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is data only and is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fpu_result_queue.sv
// Output buffer after the last FPU pipeline stage. Accepts the un-throttled
// result stream, presents it through ready/valid, and hands issue credits
// back so in-flight ops plus occupancy never exceed DEPTH.
// Optional feature: define FPU_RESULT_QUEUE_BYPASS_EN to forward a result
// straight to the output when the queue is empty (zero-latency path).
module fpu_result_queue
  import fpu_flags::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       result_valid,
  input  logic [31:0]                result,
  input  flag_set                    result_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output flag_set                    out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       protocol_error
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_W = DEPTH;

  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          err_q, err_d;
  logic [CW:0]   credit_sum;
  logic          issue_fire;
  logic          bypass_take;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  entry_t        fifo_wdata, fifo_rdata;

  fpu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_wdata = '{result: result, flags: result_flags};

  // Credits: both terms are registers, so issue_ready has no input path.
  assign credit_sum  = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign issue_ready = (credit_sum < DEPTH_W);
  assign issue_fire  = issue_valid && issue_ready;

`ifdef FPU_RESULT_QUEUE_BYPASS_EN
  // Empty queue: the incoming result is visible immediately and, if taken,
  // never touches storage.
  assign bypass_take = fifo_empty && result_valid && out_ready;
  assign out_valid   = !fifo_empty || result_valid;
  assign out_result  = fifo_empty ? result       : fifo_rdata.result;
  assign out_flags   = fifo_empty ? result_flags : fifo_rdata.flags;
`else
  assign bypass_take = 1'b0;
  assign out_valid   = !fifo_empty;
  assign out_result  = fifo_rdata.result;
  assign out_flags   = fifo_rdata.flags;
`endif

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = result_valid && !bypass_take && (!fifo_full || fifo_pop);

  // In-flight accounting and sticky protocol checks.
  always_comb begin
    in_flight_d = in_flight_q;
    if (issue_fire && !result_valid)
      in_flight_d = in_flight_q + CW'(1);
    else if (!issue_fire && result_valid && (in_flight_q != '0))
      in_flight_d = in_flight_q - CW'(1);

    err_d = err_q;
    if (issue_valid && !issue_ready)             err_d = 1'b1;
    if (result_valid && fifo_full && !fifo_pop)  err_d = 1'b1;
    if (result_valid && (in_flight_q == '0))     err_d = 1'b1;
  end

  // Credit counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  assign count          = fifo_count;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Self-checking bench for fpu_result_queue: queue-based reference model,
// randomized traffic, and directed scenarios with literal expectations.
module tb_fpu_result_queue;
  import fpu_flags::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int EW    = 32 + FLAG_WIDTH;
`ifdef FPU_RESULT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_ready;
  logic          result_valid;
  logic [31:0]   result;
  flag_set       result_flags;
  logic          out_valid, out_ready;
  logic [31:0]   out_result;
  flag_set       out_flags;
  logic [CW-1:0] count;
  logic          protocol_error;

  fpu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .result_valid   (result_valid),
    .result         (result),
    .result_flags   (result_flags),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags),
    .count          (count),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [EW-1:0] m_q[$];
  int            m_inflight;
  bit            m_err;

  // Expected outputs for the current cycle
  bit            chk_en = 1'b0;
  bit            exp_valid, exp_ready, exp_err;
  int            exp_count;
  logic [EW-1:0] exp_head;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model once per cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",          64'(count),          64'(exp_count));
      check("out_valid",      64'(out_valid),      64'(exp_valid));
      check("issue_ready",    64'(issue_ready),    64'(exp_ready));
      check("protocol_error", 64'(protocol_error), 64'(exp_err));
      if (exp_valid)
        check("out_data", 64'({out_result, out_flags}), 64'(exp_head));
    end
  end

  // One clock cycle: drive inputs, publish expectations, advance the model.
  task automatic cyc(bit iv, bit rv, logic [31:0] r, logic [4:0] f, bit ordy);
    int sz;
    bit fire, pop, take, push;
    issue_valid  = iv;
    result_valid = rv;
    result       = r;
    result_flags = flag_set'(f);
    out_ready    = ordy;
    sz        = m_q.size();
    exp_count = sz;
    exp_ready = (m_inflight + sz) < DEPTH;
    exp_valid = (sz > 0) || (BYP && rv);
    exp_head  = (sz > 0) ? m_q[0] : {r, f};
    exp_err   = m_err;
    chk_en    = 1'b1;
    @(posedge clk);
    fire = iv && exp_ready;
    pop  = (sz > 0) && ordy;
    take = BYP && (sz == 0) && rv && ordy;
    push = rv && !take && ((sz < DEPTH) || pop);
    if (iv && !exp_ready)             m_err = 1'b1;
    if (rv && (sz == DEPTH) && !pop)  m_err = 1'b1;
    if (rv && (m_inflight == 0))      m_err = 1'b1;
    if (fire && !rv)                          m_inflight++;
    else if (!fire && rv && (m_inflight > 0)) m_inflight--;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({r, f});
    #2;
  endtask

  task automatic idle(bit ordy);
    cyc(1'b0, 1'b0, 32'h0, 5'h0, ordy);
  endtask

  task automatic do_reset();
    chk_en       = 1'b0;
    issue_valid  = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    result_flags = '0;
    out_ready    = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    m_q.delete();
    m_inflight = 0;
    m_err      = 1'b0;
    reset      = 1'b0;
  endtask

  logic [31:0] vals [4];

  initial begin
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
    vals[2] = 32'h40400000; vals[3] = 32'h40800000;

    // Reset state
    issue_valid = 1'b0; result_valid = 1'b0; result = '0;
    result_flags = '0; out_ready = 1'b0;
    reset = 1'b1;
    #3;
    check("rst_count",       64'(count),          64'(0));
    check("rst_out_valid",   64'(out_valid),      64'(0));
    check("rst_issue_ready", 64'(issue_ready),    64'(1));
    check("rst_error",       64'(protocol_error), 64'(0));
    do_reset();
    repeat (3) idle(1'b0);

    // Fill through credits with the consumer stalled
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    check("credits_exhausted", 64'(issue_ready), 64'(0));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, vals[i], 5'(i + 1), 1'b0);
    check("fill_count", 64'(count),      64'(4));
    check("fill_head",  64'(out_result), 64'(32'h3F800000));
    idle(1'b1);
    check("credit_after_pop", 64'(issue_ready), 64'(1));
    check("second_head",      64'(out_result),  64'(32'h40000000));
    repeat (4) idle(1'b1);
    check("drained_count", 64'(count), 64'(0));

    // Streaming: one issue, one result, one pop every cycle
    cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b1);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, 32'h41000000 + 32'(i), 5'(i), 1'b1);
`ifdef FPU_RESULT_QUEUE_BYPASS_EN
    check("stream_count", 64'(count), 64'(0));
`else
    check("stream_count", 64'(count), 64'(1));
`endif
    cyc(1'b0, 1'b1, 32'h42000000, 5'h1F, 1'b1);
    repeat (2) idle(1'b1);
    check("stream_error", 64'(protocol_error), 64'(0));

    // Randomized traffic, mostly credit-respecting
    for (int i = 0; i < 300; i++) begin
      bit iv, rv, ordy;
      iv   = ((m_inflight + m_q.size()) < DEPTH) ? ($urandom_range(0, 2) != 0)
                                                 : ($urandom_range(0, 63) == 0);
      rv   = (m_inflight > 0) ? ($urandom_range(0, 2) != 0)
                              : ($urandom_range(0, 63) == 0);
      ordy = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(iv, rv, $urandom, 5'($urandom), ordy);
    end

    // Result with nothing in flight sets the sticky error
    do_reset();
    cyc(1'b0, 1'b1, 32'h3F800000, 5'h0, 1'b0);
    check("err_orphan_result", 64'(protocol_error), 64'(1));
    repeat (3) idle(1'b1);
    check("err_sticky", 64'(protocol_error), 64'(1));

    // Issue without a credit sets the sticky error
    do_reset();
    check("err_cleared", 64'(protocol_error), 64'(0));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    check("err_overissue", 64'(protocol_error), 64'(1));

    // Full queue: push with a simultaneous pop is accepted, push alone dropped
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, vals[i], 5'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h40A00000, 5'h04, 1'b1);
    check("full_pushpop_count", 64'(count),      64'(4));
    check("full_pushpop_head",  64'(out_result), 64'(32'h40000000));
    cyc(1'b0, 1'b1, 32'h40C00000, 5'h08, 1'b0);
    check("full_drop_count", 64'(count), 64'(4));
    repeat (5) idle(1'b1);

    // Asynchronous reset with 3 queued and 1 in flight
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 5'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, vals[i], 5'h0, 1'b0);
    chk_en       = 1'b0;
    issue_valid  = 1'b0;
    result_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_count",       64'(count),       64'(0));
    check("async_rst_out_valid",   64'(out_valid),   64'(0));
    check("async_rst_issue_ready", 64'(issue_ready), 64'(1));
    @(posedge clk);
    #2;
    m_q.delete();
    m_inflight = 0;
    m_err      = 1'b0;
    reset      = 1'b0;
    repeat (4) idle(1'b1);

    chk_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
